// File: rtl/cov_sum_accumulator.sv
// cov_sum_accumulator
// Counts distinct coverage points hit since the last reset or clear. A sticky
// bitmap keeps only first-time hits, a two-stage popcount pipeline turns them
// into an increment, and that increment goes into a saturating running sum.

module cov_sum_accumulator #(
    parameter int NUM_POINTS = 256,
    parameter int CHUNK      = 32,
    parameter int SUM_W      = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hit_valid,
    input  logic [NUM_POINTS-1:0] hit,
    input  logic                  clear,
    output logic [SUM_W-1:0]      cov_sum,
    output logic                  cov_new,
    output logic                  saturated,
    output logic [NUM_POINTS-1:0] bitmap_out
);

    localparam int NUM_CHUNKS = NUM_POINTS / CHUNK;
    localparam int PART_W     = $clog2(CHUNK + 1);
    localparam int INC_W      = $clog2(NUM_POINTS + 1);
    // One bit wider than the wider operand, so overflow past all-ones is visible.
    localparam int ADD_W      = ((SUM_W > INC_W) ? SUM_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    logic [NUM_POINTS-1:0] bitmap;
    logic [NUM_POINTS-1:0] new_bits;
    logic [PART_W-1:0]     part      [NUM_CHUNKS];
    logic [PART_W-1:0]     part_next [NUM_CHUNKS];
    logic                  s1_valid;
    logic [INC_W-1:0]      inc;
    logic [ADD_W-1:0]      sum_wide;
    logic [SUM_W-1:0]      sum_next;
    logic                  sat_next;

    // Points seen for the first time this round; X on hit is masked off when not valid.
    always_comb begin
        new_bits = hit_valid ? (hit & ~bitmap) : '0;
    end

    // Stage-1 partial popcounts, one per CHUNK-bit slice of the new bits.
    always_comb begin
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            // NOTE: every combinational output is assigned a default before any
            // conditional or accumulating update, so no latch is inferred.
            part_next[k] = '0;
            for (int b = 0; b < CHUNK; b++) begin
                part_next[k] = part_next[k] + PART_W'(new_bits[k*CHUNK + b]);
            end
        end
    end

    // Stage-2 increment and saturating sum computed from the registered partials.
    always_comb begin
        inc = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            inc = inc + INC_W'(part[k]);
        end
        sum_wide = ADD_W'(cov_sum) + ADD_W'(inc);
        if (sum_wide >= ADD_W'(SUM_MAX)) begin
            sum_next = SUM_MAX;
        end else begin
            sum_next = sum_wide[SUM_W-1:0];
        end
        sat_next = (sum_next == SUM_MAX);
    end

    // Stage 1: update the sticky bitmap and capture partials at the same edge,
    // so a point hit on consecutive cycles is only ever counted once.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset || clear) begin
            bitmap   <= '0;
            s1_valid <= 1'b0;
            // NOTE: the partial array is a handful of small registers, not a RAM,
            // so it is cleared explicitly; a stale partial would corrupt the sum.
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                part[k] <= '0;
            end
        end else begin
            bitmap   <= bitmap | new_bits;
            s1_valid <= |new_bits;
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                part[k] <= part_next[k];
            end
        end
    end

    // Stage 2: accumulate into the saturating sum; clear drops any in-flight increment.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cov_sum   <= '0;
            cov_new   <= 1'b0;
            saturated <= 1'b0;
        end else if (s1_valid) begin
            cov_sum <= sum_next;
            cov_new <= (inc != '0) && !saturated;
            if (sat_next) begin
                saturated <= 1'b1;
            end
        end else begin
            cov_new <= 1'b0;
        end
    end

    assign bitmap_out = bitmap;

endmodule

// File: tb/tb_cov_sum_accumulator.sv
// tb_cov_sum_accumulator
// Directed test of cov_sum_accumulator: reset state, two-cycle latency,
// duplicate suppression, full-vector counting, clear mid-pipeline and
// saturation. A second instance with an 8-bit sum exercises saturation;
// both instances share the same stimulus.

module tb_cov_sum_accumulator;

    localparam int NP = 256;

    logic          clock = 1'b0;
    logic          reset;
    logic          hit_valid;
    logic [NP-1:0] hit;
    logic          clear;

    logic [29:0]   cov_sum;
    logic          cov_new;
    logic          saturated;
    logic [NP-1:0] bitmap_out;

    logic [7:0]    cov_sum8;
    logic          cov_new8;
    logic          saturated8;
    logic [NP-1:0] bitmap_out8;

    int tests  = 0;
    int failed = 0;
    int pulses;
    logic [NP-1:0] exp_vec;

    always #5 clock = ~clock;

    cov_sum_accumulator #(.NUM_POINTS(NP), .CHUNK(32), .SUM_W(30)) dut (
        .clock      (clock),
        .reset      (reset),
        .hit_valid  (hit_valid),
        .hit        (hit),
        .clear      (clear),
        .cov_sum    (cov_sum),
        .cov_new    (cov_new),
        .saturated  (saturated),
        .bitmap_out (bitmap_out)
    );

    cov_sum_accumulator #(.NUM_POINTS(NP), .CHUNK(32), .SUM_W(8)) dut8 (
        .clock      (clock),
        .reset      (reset),
        .hit_valid  (hit_valid),
        .hit        (hit),
        .clear      (clear),
        .cov_sum    (cov_sum8),
        .cov_new    (cov_new8),
        .saturated  (saturated8),
        .bitmap_out (bitmap_out8)
    );

    task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        hit_valid = 1'b0;
        hit       = '0;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        hit_valid = 1'b0;
        hit       = '0;

        // Reset state held for 10 idle cycles
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_sum", NP'(cov_sum), '0);
            check("rst_new", NP'(cov_new), '0);
            check("rst_sat", NP'(saturated), '0);
            check("rst_bitmap", bitmap_out, '0);
        end
        check("rst_sat8", NP'(saturated8), '0);

        // Single hit on point 5: visible two edges later, pulse lasts one cycle
        hit = '0; hit[5] = 1'b1; hit_valid = 1'b1;
        step();
        hit_valid = 1'b0; hit = '0;
        check("lat_early_sum", NP'(cov_sum), '0);
        step();
        check("lat_sum", NP'(cov_sum), NP'(1));
        check("lat_new", NP'(cov_new), NP'(1));
        exp_vec = '0; exp_vec[5] = 1'b1;
        check("lat_bitmap", bitmap_out, exp_vec);
        step();
        check("lat_new_off", NP'(cov_new), '0);
        check("lat_sum_hold", NP'(cov_sum), NP'(1));

        // Repeated 0x3 then 0x6: three distinct points, two increments
        do_clear();
        check("clr_sum", NP'(cov_sum), '0);
        pulses = 0;
        hit_valid = 1'b1; hit = NP'(3);
        for (int i = 0; i < 4; i++) begin
            step();
            pulses += int'(cov_new);
        end
        hit = NP'(6);
        step();
        pulses += int'(cov_new);
        hit_valid = 1'b0; hit = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(cov_new);
        end
        check("dup_sum", NP'(cov_sum), NP'(3));
        check("dup_pulses", NP'(pulses), NP'(2));
        check("dup_bitmap", bitmap_out, NP'(7));

        // hit_valid low: a full vector is ignored
        hit = '1; hit_valid = 1'b0;
        repeat (3) step();
        check("inval_sum", NP'(cov_sum), NP'(3));
        check("inval_bitmap", bitmap_out, NP'(7));
        hit = '0;

        // Full vector across all chunks; 8-bit instance saturates at 255
        do_clear();
        hit = '1; hit_valid = 1'b1;
        step();
        hit_valid = 1'b0; hit = '0;
        step();
        check("full_sum", NP'(cov_sum), NP'(256));
        check("full_new", NP'(cov_new), NP'(1));
        check("full_sat", NP'(saturated), '0);
        check("sat8_sum", NP'(cov_sum8), NP'(255));
        check("sat8_flag", NP'(saturated8), NP'(1));
        check("sat8_new", NP'(cov_new8), NP'(1));
        step();
        check("full_new_off", NP'(cov_new), '0);
        check("sat8_new_off", NP'(cov_new8), '0);
        hit = '1; hit_valid = 1'b1;
        step();
        hit_valid = 1'b0; hit = '0;
        step();
        check("full_repeat_sum", NP'(cov_sum), NP'(256));
        check("full_repeat_new", NP'(cov_new), '0);
        check("full_bitmap", bitmap_out, {NP{1'b1}});
        check("sat8_repeat_sum", NP'(cov_sum8), NP'(255));

        // Clear one cycle after a hit discards it; a hit during clear is ignored
        do_clear();
        check("clr_sat8", NP'(saturated8), '0);
        hit = NP'(32'hF); hit_valid = 1'b1;
        step();
        clear = 1'b1; hit = NP'(32'h10); hit_valid = 1'b1;
        step();
        clear = 1'b0; hit = '0; hit_valid = 1'b0;
        check("mid_sum", NP'(cov_sum), '0);
        check("mid_bitmap", bitmap_out, '0);
        check("mid_new", NP'(cov_new), '0);
        step();
        check("mid_sum_later", NP'(cov_sum), '0);
        check("mid_new_later", NP'(cov_new), '0);
        hit = NP'(1); hit_valid = 1'b1;
        step();
        hit = '0; hit_valid = 1'b0;
        step();
        check("post_clr_sum", NP'(cov_sum), NP'(1));
        check("post_clr_new", NP'(cov_new), NP'(1));
        hit = NP'(32'h10); hit_valid = 1'b1;
        step();
        hit = '0; hit_valid = 1'b0;
        step();
        check("clr_hit_ignored", NP'(cov_sum), NP'(2));

        // Reach exactly 255, then one more new point: sum holds, no pulse
        do_clear();
        hit = '1; hit[255] = 1'b0; hit_valid = 1'b1;
        step();
        hit = '0; hit_valid = 1'b0;
        step();
        check("exact_sum8", NP'(cov_sum8), NP'(255));
        check("exact_sat8", NP'(saturated8), NP'(1));
        check("exact_new8", NP'(cov_new8), NP'(1));
        check("exact_sum", NP'(cov_sum), NP'(255));
        step();
        hit = '0; hit[255] = 1'b1; hit_valid = 1'b1;
        step();
        hit = '0; hit_valid = 1'b0;
        step();
        check("held_sum8", NP'(cov_sum8), NP'(255));
        check("held_new8", NP'(cov_new8), '0);
        check("held_sat8", NP'(saturated8), NP'(1));
        check("held_sum", NP'(cov_sum), NP'(256));
        check("held_new", NP'(cov_new), NP'(1));

        // Reset wins over clear and drops the sticky flag
        reset = 1'b1; clear = 1'b1;
        step();
        reset = 1'b0; clear = 1'b0;
        check("rst2_sat8", NP'(saturated8), '0);
        check("rst2_sum", NP'(cov_sum), '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
